// File: rtl/datamover_tail_masker_pkg.sv
// Shared types and constants for the datamover tail-masking stream stage.
// The top-level datamover FSM uses the ctrl/flags structs to talk to the stage.
package datamover_tail_masker_pkg;

    localparam int unsigned TAIL_DW       = 256;
    localparam int unsigned TAIL_LENW     = 32;
    localparam int unsigned TAIL_BPB      = TAIL_DW / 8;
    localparam int unsigned TAIL_BPB_LOG2 = $clog2(TAIL_BPB);

    typedef enum logic [1:0] {
        TAIL_IDLE,
        TAIL_RUN,
        TAIL_FLUSH,
        TAIL_DONE
    } tail_state_t;

    typedef struct packed {
        logic                 start;
        logic [TAIL_LENW-1:0] len;
    } ctrl_tail_t;

    typedef struct packed {
        logic                 busy;
        logic                 done;
        logic [TAIL_LENW-1:0] beat_cnt;
    } flags_tail_t;

endpackage

// File: rtl/datamover_tail_masker.sv
// Registered stream stage that forwards exactly ceil(len/BPB) beats, masks the
// strobe/data bytes past the byte length on the final beat and pulses done_o.
module datamover_tail_masker
    import datamover_tail_masker_pkg::*;
#(
    parameter int unsigned DW   = TAIL_DW,
    parameter int unsigned LENW = TAIL_LENW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic [LENW-1:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LENW-1:0]   beat_cnt_o,
    input  logic [DW-1:0]     data_in_data_i,
    input  logic [DW/8-1:0]   data_in_strb_i,
    input  logic              data_in_valid_i,
    output logic              data_in_ready_o,
    output logic [DW-1:0]     data_out_data_o,
    output logic [DW/8-1:0]   data_out_strb_o,
    output logic              data_out_valid_o,
    input  logic              data_out_ready_i
);

    localparam int unsigned BPB      = DW / 8;
    localparam int unsigned BPB_LOG2 = $clog2(BPB);

    tail_state_t         state_q, state_d;
    logic [LENW-1:0]     n_beats_q, n_beats_d;
    logic [BPB_LOG2:0]   last_bytes_q, last_bytes_d;
    logic [LENW-1:0]     beat_cnt_q, beat_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic [BPB-1:0]      out_strb_q, out_strb_d;

    logic                in_hs, out_hs, last_beat;
    logic [BPB-1:0]      tail_mask, strb_masked;
    logic [DW-1:0]       data_masked;

    // Combinational ready path: a beat can enter whenever the output slot frees up this cycle.
    assign data_in_ready_o = enable_i & (state_q == TAIL_RUN) & (~out_valid_q | data_out_ready_i);
    assign in_hs           = data_in_ready_o & data_in_valid_i;
    assign out_hs          = enable_i & out_valid_q & data_out_ready_i;
    assign last_beat       = (beat_cnt_q == n_beats_q - LENW'(1));

    always_comb begin
        tail_mask = '1;
        if (last_beat) begin
            for (int b = 0; b < BPB; b++) begin
                tail_mask[b] = ((BPB_LOG2 + 1)'(b) < last_bytes_q);
            end
        end
        strb_masked = data_in_strb_i & tail_mask;
        for (int b = 0; b < BPB; b++) begin
            data_masked[8*b +: 8] = strb_masked[b] ? data_in_data_i[8*b +: 8] : 8'h00;
        end
    end

    // NOTE: every next-state signal takes its held value first, so no path through
    // this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        n_beats_d    = n_beats_q;
        last_bytes_d = last_bytes_q;
        beat_cnt_d   = beat_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_strb_d   = out_strb_q;

        if (enable_i) begin
            unique case (state_q)
                TAIL_IDLE: begin
                    if (start_i) begin
                        beat_cnt_d   = '0;
                        n_beats_d    = LENW'(len_i >> BPB_LOG2) + LENW'(|len_i[BPB_LOG2-1:0]);
                        last_bytes_d = (len_i[BPB_LOG2-1:0] == '0) ? (BPB_LOG2 + 1)'(BPB)
                                                                   : {1'b0, len_i[BPB_LOG2-1:0]};
                        state_d      = (len_i == '0) ? TAIL_DONE : TAIL_RUN;
                    end
                end
                TAIL_RUN:   if (in_hs && last_beat) state_d = TAIL_FLUSH;
                TAIL_FLUSH: if (out_hs)             state_d = TAIL_DONE;
                TAIL_DONE:                          state_d = TAIL_IDLE;
                default:                            state_d = TAIL_IDLE;
            endcase

            if (in_hs) begin
                out_valid_d = 1'b1;
                out_data_d  = data_masked;
                out_strb_d  = strb_masked;
                beat_cnt_d  = beat_cnt_q + LENW'(1);
            end else if (out_hs) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from values sampled at the same clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= TAIL_IDLE;
            n_beats_q    <= '0;
            last_bytes_q <= '0;
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
        end else if (clear_i) begin
            state_q      <= TAIL_IDLE;
            n_beats_q    <= '0;
            last_bytes_q <= '0;
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_strb_q   <= '0;
        end else begin
            state_q      <= state_d;
            n_beats_q    <= n_beats_d;
            last_bytes_q <= last_bytes_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_strb_q   <= out_strb_d;
        end
    end

    assign busy_o           = (state_q != TAIL_IDLE);
    assign done_o           = (state_q == TAIL_DONE);
    assign beat_cnt_o       = beat_cnt_q;
    assign data_out_valid_o = out_valid_q;
    assign data_out_data_o  = out_data_q;
    assign data_out_strb_o  = out_strb_q;

endmodule
